// File: rtl/pattern_judge.sv
// Round judge for the memory game: latches the LED pattern, checks each button
// press against it and requests a pass/fail tone from the piezo block.
module pattern_judge #(
  parameter int SEQ_LEN        = 4,
  parameter int TONE_CYCLES    = 2_000_000,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                   clk_1mhz,
  input  logic                   rst,
  input  logic                   pattern_valid,
  input  logic [3*SEQ_LEN-1:0]   pattern_in,
  input  logic [7:0]             btn,
  output logic                   enable,
  output logic                   equal,
  output logic                   busy,
  output logic [3:0]             step
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SOUND   = 2'd2
  } state_t;

  localparam logic [22:0] TONE_LAST    = 23'(TONE_CYCLES - 1);
  localparam logic [22:0] TIMEOUT_LAST = 23'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  STEP_LAST    = 4'(SEQ_LEN - 1);

  state_t               state_reg, state_next;
  logic [3*SEQ_LEN-1:0] pattern_reg, pattern_next;
  logic [3:0]           step_reg, step_next;
  logic [22:0]          timeout_reg, timeout_next;
  logic [22:0]          tone_reg, tone_next;
  logic                 enable_reg, enable_next;
  logic                 equal_reg, equal_next;
  logic                 busy_reg, busy_next;

  // Pattern unpacked into a full 8-entry table so a 3-bit step index always
  // lands inside the array; entries beyond SEQ_LEN are never reached.
  logic [2:0] pat_step [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pat_step
      if (gi < SEQ_LEN) begin : g_used
        assign pat_step[gi] = pattern_reg[3*gi +: 3];
      end else begin : g_unused
        assign pat_step[gi] = 3'd0;
      end
    end
  endgenerate

  logic       btn_any;
  logic       btn_one;
  logic [2:0] btn_idx;
  logic       press_ok;

  assign btn_any = |btn;
  assign btn_one = btn_any && ((btn & (btn - 8'd1)) == 8'd0);

  always_comb begin
    btn_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (btn[i]) btn_idx = 3'(i);
    end
  end

  // Multi-bit presses never match, so they fall into the fail path.
  assign press_ok = btn_one && (btn_idx == pat_step[step_reg[2:0]]);

  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    step_next    = step_reg;
    timeout_next = timeout_reg;
    tone_next    = tone_reg;
    equal_next   = equal_reg;

    case (state_reg)
      IDLE: begin
        if (pattern_valid) begin
          pattern_next = pattern_in;
          step_next    = 4'd0;
          timeout_next = 23'd0;
          state_next   = COLLECT;
        end
      end

      COLLECT: begin
        if (btn_any) begin
          if (press_ok && (step_reg != STEP_LAST)) begin
            step_next    = step_reg + 4'd1;
            timeout_next = 23'd0;
          end else begin
            equal_next = press_ok;
            tone_next  = 23'd0;
            state_next = SOUND;
          end
        end else if (timeout_reg == TIMEOUT_LAST) begin
          equal_next = 1'b0;
          tone_next  = 23'd0;
          state_next = SOUND;
        end else begin
          timeout_next = timeout_reg + 23'd1;
        end
      end

      SOUND: begin
        if (tone_reg == TONE_LAST) begin
          state_next = IDLE;
        end else begin
          tone_next = tone_reg + 23'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    enable_next = (state_next == SOUND);
    busy_next   = (state_next != IDLE);
  end

  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      step_reg    <= 4'd0;
      timeout_reg <= 23'd0;
      tone_reg    <= 23'd0;
      enable_reg  <= 1'b0;
      equal_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pattern_reg <= pattern_next;
      step_reg    <= step_next;
      timeout_reg <= timeout_next;
      tone_reg    <= tone_next;
      enable_reg  <= enable_next;
      equal_reg   <= equal_next;
      busy_reg    <= busy_next;
    end
  end

  assign enable = enable_reg;
  assign equal  = equal_reg;
  assign busy   = busy_reg;
  assign step   = step_reg;

endmodule

// File: doc/pattern_judge.md
# pattern_judge

Upstream game-logic stage for the piezo tone block. It captures the LED pattern from the pattern generator, collects the player's button presses, and compares them step by step against that pattern. When a round ends, it drives `enable` and `equal` to the piezo block for exactly one tone duration. `equal` = 1 selects the "correct" tone; `equal` = 0 selects the "wrong" tone.

## Interface
- `SEQ_LEN`, default 4: pattern steps per round, range 1..8.
- `TONE_CYCLES`, default 2_000_000: `enable` high time in clk cycles (2 s at 1 MHz); matches the piezo tone duration.
- `TIMEOUT_CYCLES`, default 5_000_000: maximum idle gap allowed between presses (5 s).
- `clk_1mhz`  in  1: single clock, 1 MHz.
- `rst`  in  1: synchronous, active-high reset.
- `pattern_valid`  in  1: single-cycle strobe; `pattern_in` is valid in this cycle.
- `pattern_in`  in  3*SEQ_LEN: step k LED index at bits [3k+2:3k]; step 0 is played first.
- `btn`  in  8: debounced press pulses, one cycle per press; bit i = LED i.
- `enable`  out  1: tone request to the piezo block.
- `equal`  out  1: round result (1 = pass, 0 = fail); stable whenever `enable` = 1.
- `busy`  out  1: high in COLLECT and SOUND.
- `step`  out  4: number of correct presses so far in this round.

## Operation
- FSM states: IDLE, COLLECT, SOUND. All outputs are registered.
- IDLE:
  - `pattern_valid` = 1: latch `pattern_in`, clear `step`, clear the timeout counter, go to COLLECT.
  - `btn` is ignored.
- COLLECT:
  - `btn` = 0: no press. The timeout counter increments.
  - Exactly one bit i set (valid press): encode i and compare it to the pattern at `step`.
    - Mismatch: result = 0, go to SOUND.
    - Match and `step` = SEQ_LEN-1: result = 1, go to SOUND.
    - Match otherwise: `step` +1, clear the timeout counter.
  - Two or more bits set in one cycle: counts as a mismatch; result = 0, go to SOUND.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no press: result = 0, go to SOUND. If a press and timeout expiry land on the same cycle, the press wins.
  - `pattern_valid` is ignored.
- SOUND:
  - `enable` = 1 and `equal` = result.
  - The tone counter runs 0..TONE_CYCLES-1. At the end, go to IDLE with `enable` = 0.
  - `btn` and `pattern_valid` are ignored.
- `equal` keeps its last result after SOUND ends, until the next entry to SOUND or reset.
- `step` is not cleared on leaving COLLECT. It holds the progress count until the next `pattern_valid` is accepted.
- Counter widths:
  - Tone and timeout counters: 23 bits, enough for 5_000_000.
  - `step`: 4 bits, never exceeds SEQ_LEN-1.
  - No wrap-around is possible within the legal parameter range.

## Timing
- Reset values: state IDLE, `enable` 0, `equal` 0, `busy` 0, `step` 0, pattern register 0, all counters 0.
- Reset in any state wins over every other input on that edge, including reset mid-SOUND: `enable` drops on the next cycle.
- `pattern_valid` is sampled at edge t. From cycle t+1: `busy` = 1, and a press sampled at edge t+1 is already evaluated.
- A deciding press (or timeout) is sampled at edge t:
  - `enable` = 1 and `equal` = result from cycle t+1.
  - `enable` stays high for exactly TONE_CYCLES cycles, then falls. `busy` falls on the same edge.
- `equal` never changes while `enable` = 1, because the piezo block re-selects its tone every cycle.
- Back-to-back rounds: a `pattern_valid` in the first IDLE cycle after SOUND is accepted.

## Test plan
Simulation parameters: SEQ_LEN=4, TONE_CYCLES=20, TIMEOUT_CYCLES=50. Pattern is 3,1,7,0, i.e. `pattern_in` = 12'b000_111_001_011.
- Correct round: press `btn` = 08, 02, 80, 01, 10 cycles apart -> `step` steps 1,2,3; `enable` = 1 and `equal` = 1 the cycle after the 4th press, for exactly 20 cycles; then `busy` = 0.
- Wrong second press: `btn` = 08 then 04 -> `step` = 1; `enable` = 1 and `equal` = 0 for 20 cycles, starting the cycle after the 04 press.
- Multi-bit press: `btn` = 0A as the first press -> fail (`equal` = 0); `step` stays 0.
- Timeout: one correct press, then 50 idle cycles -> `enable` = 1 and `equal` = 0; press then timeout on the same cycle -> the press is evaluated instead.
- Reset mid-SOUND: assert `rst` at tone cycle 10 -> all outputs 0 the next cycle; a later `pattern_valid` starts a fresh round.
- Ignored inputs: `pattern_valid` with a different pattern during COLLECT, and `btn` pulses during SOUND -> no effect; the original pattern still passes.
